// File: rtl/if_stage_if.sv
// if_stage_if: pre-IF, instruction SRAM and ID handshake bundle around the IF stage
interface if_stage_if;
  logic pre_IF_IF_valid;
  logic [31:0] pre_IF_IF_pc;
  logic pre_IF_IF_exception;
  logic [4:0] pre_IF_IF_exccode;
  logic pre_IF_IF_tlb_refill;
  logic IF_allow_in;
  logic inst_req_accepted;
  logic inst_sram_data_ok;
  logic [31:0] inst_sram_rdata;
  logic flush;
  logic IF_stall_wait_for_data;
  logic ID_allow_in;
  logic IF_ID_valid;
  logic [31:0] IF_ID_pc;
  logic [31:0] IF_ID_inst;
  logic IF_ID_exception;
  logic [4:0] IF_ID_exccode;
  logic IF_ID_tlb_refill;
  modport master (
    output pre_IF_IF_valid, pre_IF_IF_pc, pre_IF_IF_exception, pre_IF_IF_exccode, pre_IF_IF_tlb_refill,
    output inst_req_accepted, inst_sram_data_ok, inst_sram_rdata, flush, ID_allow_in,
    input IF_allow_in, IF_stall_wait_for_data, IF_ID_valid, IF_ID_pc, IF_ID_inst,
    input IF_ID_exception, IF_ID_exccode, IF_ID_tlb_refill
  );
  modport slave (
    input pre_IF_IF_valid, pre_IF_IF_pc, pre_IF_IF_exception, pre_IF_IF_exccode, pre_IF_IF_tlb_refill,
    input inst_req_accepted, inst_sram_data_ok, inst_sram_rdata, flush, ID_allow_in,
    output IF_allow_in, IF_stall_wait_for_data, IF_ID_valid, IF_ID_pc, IF_ID_inst,
    output IF_ID_exception, IF_ID_exccode, IF_ID_tlb_refill
  );
endinterface

// File: rtl/if_stage.sv
// if_stage: holds the accepted PC, buffers its instruction for ID, forwards pre-IF exceptions and drops stale responses after a flush
module if_stage #(
  parameter int DISCARD_W = 2
) (
  input logic clk,
  input logic reset,
  if_stage_if.slave bus
);
  logic valid, exc, refill, have_inst;
  logic [31:0] pc, inst_buf;
  logic [4:0] exccode;
  logic [DISCARD_W-1:0] discard_cnt;
  logic data_live, data_stale, ready, leaving, outstanding;
  logic [DISCARD_W:0] flush_cnt;
  assign data_live = bus.inst_sram_data_ok & (discard_cnt == '0);
  assign data_stale = bus.inst_sram_data_ok & (discard_cnt != '0);
  assign ready = exc | have_inst | data_live;
  assign bus.IF_ID_valid = valid & ready & !bus.flush;
  assign leaving = bus.IF_ID_valid & bus.ID_allow_in;
  assign bus.IF_allow_in = !valid | leaving;
  assign outstanding = valid & !exc & !have_inst & !data_live;
  assign bus.IF_stall_wait_for_data = outstanding;
  assign bus.IF_ID_pc = pc;
  assign bus.IF_ID_inst = exc ? '0 : have_inst ? inst_buf : bus.inst_sram_rdata;
  assign bus.IF_ID_exception = exc;
  assign bus.IF_ID_exccode = exccode;
  assign bus.IF_ID_tlb_refill = refill;
  assign flush_cnt = {1'b0, discard_cnt} - (DISCARD_W+1)'(data_stale)
                   + (DISCARD_W+1)'(outstanding) + (DISCARD_W+1)'(bus.inst_req_accepted);
  always_ff @(posedge clk) begin
    if (reset) begin
      valid <= 1'b0;
      pc <= '0;
      exc <= 1'b0;
      exccode <= '0;
      refill <= 1'b0;
      have_inst <= 1'b0;
      inst_buf <= '0;
      discard_cnt <= '0;
    end else if (bus.flush) begin
      valid <= 1'b0;
      have_inst <= 1'b0;
      discard_cnt <= flush_cnt[DISCARD_W-1:0];
    end else begin
      discard_cnt <= discard_cnt - DISCARD_W'(data_stale);
      if (bus.pre_IF_IF_valid & bus.IF_allow_in) begin
        valid <= 1'b1;
        pc <= bus.pre_IF_IF_pc;
        exc <= bus.pre_IF_IF_exception;
        exccode <= bus.pre_IF_IF_exccode;
        refill <= bus.pre_IF_IF_tlb_refill;
        have_inst <= 1'b0;
      end else if (leaving) begin
        valid <= 1'b0;
        have_inst <= 1'b0;
      end else if (data_live & valid & !have_inst & !exc) begin
        inst_buf <= bus.inst_sram_rdata;
        have_inst <= 1'b1;
      end
    end
  end
  a_live_needs_waiter: assert property (@(posedge clk) disable iff (reset)
    !(data_live & !(valid & !exc & !have_inst)));
  a_discard_overflow: assert property (@(posedge clk) disable iff (reset)
    !(bus.flush & flush_cnt[DISCARD_W]));
endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: directed and random checks of if_stage against a request-tagging reference model
module tb_if_stage;
  logic clk = 1'b0;
  logic reset;
  int checks = 0;
  int errors = 0;
  int delivered = 0;
  typedef struct {
    int id;
    logic [31:0] data;
  } req_t;
  req_t mem_q[$];
  logic m_valid, m_exc, m_ref, m_got;
  logic [31:0] m_pc, m_buf;
  logic [4:0] m_code;
  int m_id, next_id;
  if_stage_if bus();
  if_stage dut (.clk(clk), .reset(reset), .bus(bus.slave));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic drive_idle();
    bus.pre_IF_IF_valid = 1'b0;
    bus.pre_IF_IF_pc = '0;
    bus.pre_IF_IF_exception = 1'b0;
    bus.pre_IF_IF_exccode = '0;
    bus.pre_IF_IF_tlb_refill = 1'b0;
    bus.inst_req_accepted = 1'b0;
    bus.inst_sram_data_ok = 1'b0;
    bus.inst_sram_rdata = '0;
    bus.flush = 1'b0;
    bus.ID_allow_in = 1'b0;
  endtask
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    drive_idle();
    m_valid = 1'b0;
    m_got = 1'b0;
    m_exc = 1'b0;
    mem_q.delete();
    @(posedge clk);
    @(negedge clk);
    chk("rst_valid", 32'(bus.IF_ID_valid), 32'd0);
    chk("rst_allow", 32'(bus.IF_allow_in), 32'd1);
    chk("rst_stall", 32'(bus.IF_stall_wait_for_data), 32'd0);
    chk("rst_inst", bus.IF_ID_inst, 32'd0);
    reset = 1'b0;
  endtask
  // one clock: pv/ppc/pe/pcode/pr offer an entry, rd is the data of any request issued now,
  // dok returns the oldest pending response, fl flushes, ida is ID readiness, fl_req a request issued on flush
  task automatic cyc(input logic pv, input logic [31:0] ppc, input logic pe, input logic [4:0] pcode,
                     input logic pr, input logic [31:0] rd, input logic dok, input logic fl,
                     input logic ida, input logic fl_req);
    logic d, f, live, ev, ea, ld, rq;
    logic [31:0] hd;
    @(negedge clk);
    d = dok && mem_q.size() > 0;
    f = fl && mem_q.size() <= 2;
    hd = d ? mem_q[0].data : 32'h0;
    live = d && m_valid && !m_exc && !m_got && mem_q[0].id == m_id;
    ev = m_valid && (m_exc || m_got || live) && !f;
    ea = !m_valid || (ev && ida);
    ld = !f && pv && ea;
    rq = f ? fl_req : (ld && !pe);
    bus.pre_IF_IF_valid = pv;
    bus.pre_IF_IF_pc = ppc;
    bus.pre_IF_IF_exception = pe;
    bus.pre_IF_IF_exccode = pcode;
    bus.pre_IF_IF_tlb_refill = pr;
    bus.inst_req_accepted = rq;
    bus.inst_sram_data_ok = d;
    bus.inst_sram_rdata = d ? hd : $urandom;
    bus.flush = f;
    bus.ID_allow_in = ida;
    #1;
    chk("valid", 32'(bus.IF_ID_valid), 32'(ev));
    chk("allow_in", 32'(bus.IF_allow_in), 32'(ea));
    chk("stall", 32'(bus.IF_stall_wait_for_data), 32'(m_valid && !m_exc && !m_got && !live));
    if (ev) begin
      chk("pc", bus.IF_ID_pc, m_pc);
      chk("inst", bus.IF_ID_inst, m_exc ? 32'h0 : m_got ? m_buf : hd);
      chk("exc", 32'(bus.IF_ID_exception), 32'(m_exc));
      chk("exccode", 32'(bus.IF_ID_exccode), 32'(m_code));
      chk("refill", 32'(bus.IF_ID_tlb_refill), 32'(m_ref));
      if (ida) delivered++;
    end
    @(posedge clk);
    if (d) void'(mem_q.pop_front());
    if (f) begin
      m_valid = 1'b0;
      m_got = 1'b0;
      if (rq) mem_q.push_back('{-1, rd});
    end else if (ld) begin
      m_valid = 1'b1;
      m_pc = ppc;
      m_exc = pe;
      m_code = pcode;
      m_ref = pr;
      m_got = 1'b0;
      m_id = next_id++;
      if (!pe) mem_q.push_back('{m_id, rd});
    end else if (ev && ida) begin
      m_valid = 1'b0;
    end else if (live) begin
      m_got = 1'b1;
      m_buf = hd;
    end
  endtask
  initial begin
    next_id = 0;
    m_id = -2;
    do_reset();
    // fetch with immediate hit
    cyc(1, 32'hBFC00000, 0, 0, 0, 32'h24080001, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0, 0, 1, 0, 1, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    // ID stall for three cycles, accepted on the fourth
    cyc(1, 32'hBFC00000, 0, 0, 0, 32'h24080001, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    // flush while waiting, with a request accepted in the flush cycle
    cyc(1, 32'h80000010, 0, 0, 0, 32'h11111111, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    cyc(1, 32'h80000014, 0, 0, 0, 32'h22222222, 0, 1, 1, 1);
    cyc(1, 32'hBFC00380, 0, 0, 0, 32'h00000000, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0, 0, 1, 0, 1, 0);
    cyc(0, 0, 0, 0, 0, 0, 1, 0, 1, 0);
    cyc(0, 0, 0, 0, 0, 0, 1, 0, 1, 0);
    // flush coinciding with live data, then a fresh fetch must be live
    cyc(1, 32'h80000020, 0, 0, 0, 32'h33333333, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0, 0, 1, 1, 1, 0);
    cyc(1, 32'h80000024, 0, 0, 0, 32'h44444444, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0, 0, 1, 0, 1, 0);
    // exception entry, then a normal fetch proves no discard was added
    cyc(1, 32'h80000002, 1, 5'h04, 1, 0, 0, 0, 1, 0);
    cyc(1, 32'h80000030, 0, 0, 0, 32'h55555555, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0, 0, 1, 0, 1, 0);
    // streaming, one instruction per cycle
    delivered = 0;
    for (int i = 0; i <= 8; i++)
      cyc(i < 8, 32'h1000 + 32'(4 * i), 0, 0, 0, $urandom, 1, 0, 1, 0);
    chk("stream_count", 32'(delivered), 32'd8);
    // random traffic with a mid-run reset
    for (int i = 0; i < 1500; i++) begin
      if (i == 700) do_reset();
      cyc($urandom_range(0, 9) < 6, $urandom, $urandom_range(0, 9) == 0, 5'($urandom),
          1'($urandom), $urandom, $urandom_range(0, 9) < 6, $urandom_range(0, 99) < 8,
          $urandom_range(0, 9) < 7, 1'($urandom));
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage between pre-IF (issues the SRAM-like address) and ID.
- Holds the PC whose address has been accepted and waits for `inst_sram_data_ok`.
- Buffers the returned instruction while ID stalls and forwards pre-IF exceptions.
- Owns the count of stale responses to drop after a flush. This replaces any external discard flag.

Parameters:
- DISCARD_W, 2: width of the stale-response counter. Maximum count is 2^DISCARD_W-1.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- pre_IF_IF_valid  in  1  pre-IF has a PC for IF: address accepted, or exception
- pre_IF_IF_pc  in  32  PC of that entry
- pre_IF_IF_exception  in  1  entry carries an exception; no SRAM request was issued
- pre_IF_IF_exccode  in  5  exception code
- pre_IF_IF_tlb_refill  in  1  TLB refill flag
- IF_allow_in  out  1  IF can accept an entry this cycle
- inst_req_accepted  in  1  `inst_sram_req & inst_sram_addr_ok` this cycle
- inst_sram_data_ok  in  1  response valid
- inst_sram_rdata  in  32  response data
- flush  in  1  exception-like event; squash IF contents
- IF_stall_wait_for_data  out  1  IF is valid, not an exception, and has no instruction yet
- ID_allow_in  in  1  ID accepts this cycle
- IF_ID_valid  out  1  entry offered to ID
- IF_ID_pc  out  32  PC
- IF_ID_inst  out  32  instruction; 0 when exception
- IF_ID_exception  out  1  exception flag
- IF_ID_exccode  out  5  exception code
- IF_ID_tlb_refill  out  1  TLB refill flag

Behaviour:
- State registers:
  - `valid`, `pc`, `exc`, `exccode`, `refill`
  - `have_inst`, `inst_buf[31:0]`
  - `discard_cnt[DISCARD_W-1:0]`
- Reset: all registers cleared. Outputs then read `IF_ID_valid`=0, `IF_allow_in`=1, `IF_stall_wait_for_data`=0, `IF_ID_inst`=0.
- `data_live` = `inst_sram_data_ok & (discard_cnt==0)`.
- `data_stale` = `inst_sram_data_ok & (discard_cnt!=0)`.
- `ready` = `exc | have_inst | data_live`.
- `IF_ID_valid` = `valid & ready & !flush`.
- `leaving` = `IF_ID_valid & ID_allow_in`.
- `IF_allow_in` = `!valid | leaving`. It is combinational, zero-latency pass-through.
- `IF_stall_wait_for_data` = `valid & !exc & !have_inst & !data_live`.
- `IF_ID_inst` = `exc ? 0 : (have_inst ? inst_buf : inst_sram_rdata)`.
- Other IF_ID fields come from the registered entry.
- Instruction capture:
  - `data_live & valid & !have_inst & !exc & !leaving & !flush` → `inst_buf` <= rdata, `have_inst` <= 1.
  - `data_live` while IF holds no waiting entry is a protocol error. Assert it in simulation; RTL ignores it.
- Entry update, when there is no flush:
  - If `pre_IF_IF_valid & IF_allow_in`, load the new entry and clear `have_inst`.
  - Else if `leaving`, set `valid` to 0 and clear `have_inst`.
- Discard counter (priority over normal update on `flush`):
  - `outstanding` = `valid & !exc & !have_inst & !data_live`, i.e. a request whose response is still owed.
  - On `flush`: `valid`, `have_inst` <= 0. No entry is loaded that cycle, even if `pre_IF_IF_valid`.
  - On `flush`: `discard_cnt` <= `discard_cnt - data_stale + outstanding + inst_req_accepted`.
  - Without flush: `discard_cnt` <= `discard_cnt - data_stale`.
  - Overflow beyond max is a protocol error (simulation assertion). Underflow cannot occur.
- A stale response is consumed silently. It never reaches `inst_buf` or ID.
- `flush` and `data_live` in the same cycle: the response belongs to the squashed entry.
  - It is dropped.
  - It is not counted, because `outstanding`=0.
- An exception entry never waits: `ready`=1 immediately and it never increments `discard_cnt`.
- Latency:
  - Data returned the same cycle, with ID ready → reaches ID combinationally that cycle.
  - Buffered instruction → offered from the next cycle until accepted.
- Back-to-back: one instruction per cycle when `data_ok` arrives each cycle and ID is always ready.
- Reset asserted mid-operation: all state cleared, including `discard_cnt`. The memory side is reset together.

Test Plan:
1. Fetch with immediate hit:
   - Stimulus: entry pc=0xBFC00000; data_ok in the same following cycle with rdata=0x24080001; ID ready.
   - Response: IF_ID_valid=1, inst=0x24080001 that cycle, then `valid`=0.
2. ID stall:
   - Stimulus: as test 1 but ID_allow_in=0 for 3 cycles.
   - Response: inst_buf holds 0x24080001; IF_ID_valid=1 for all 3 cycles; IF_allow_in=0; accepted on the 4th cycle.
3. Flush while waiting:
   - Stimulus: entry pc=0x80000010 waiting; flush with inst_req_accepted=1.
   - Response: discard_cnt=2; the next two data_ok are dropped; the third data_ok (0x00000000 at new pc 0xBFC00380) reaches ID.
4. Flush coincides with live data:
   - Stimulus: flush and data_ok in the same cycle.
   - Response: data dropped, discard_cnt stays 0, IF_ID_valid=0.
5. Exception entry:
   - Stimulus: pre_IF_IF_exception=1, exccode=0x04, pc=0x80000002.
   - Response: IF_ID_valid=1 the next cycle, IF_ID_inst=0, exccode=0x04, no wait on data_ok, discard_cnt unchanged.
6. Streaming:
   - Stimulus: 8 consecutive entries with data_ok every cycle; ID always ready.
   - Response: 8 instructions delivered in order, one per cycle, and IF_stall_wait_for_data never asserted after the first.
